// File: rtl/spi_master_module_if.sv
// spi_master_module_if: user call/done handshake plus SPI pins for spi_master_module.
interface spi_master_module_if;
    logic       iCall;
    logic [7:0] iData;
    logic [7:0] oData;
    logic       oDone;
    logic       oBusy;
    logic       ncs;
    logic       sck;
    logic       mosi;
    logic       miso;
    modport master (input iCall, iData, miso, output oData, oDone, oBusy, ncs, sck, mosi);
    modport slave (output iCall, iData, miso, input oData, oDone, oBusy, ncs, sck, mosi);
endinterface

// File: rtl/spi_master_module.sv
// spi_master_module: SPI mode-0, 8-bit MSB-first master with a one-cycle call/done handshake.
// Define SPI_MASTER_BURST_EN to chain bytes inside one ncs-low frame.
module spi_master_module #(
    parameter int CLK_DIV = 4
) (
    input logic                 clk,
    input logic                 rst,
    spi_master_module_if.master bus
);
    localparam int DW = $clog2(CLK_DIV + 1);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_H, SHIFT_L, HOLD, GAP} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    tx_q, tx_d, rx_q, rx_d, data_q, data_d;
    logic          ncs_q, ncs_d, sck_q, sck_d, mosi_q, mosi_d;
    logic          done_q, done_d, busy_q, busy_d;
    logic          div_end, burst;
    assign div_end = div_q == DW'(CLK_DIV - 1);
`ifdef SPI_MASTER_BURST_EN
    assign burst = bus.iCall;
`else
    assign burst = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        div_d   = div_end ? '0 : div_q + 1'b1;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        ncs_d   = ncs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (bus.iCall) begin
                    tx_d    = bus.iData;
                    mosi_d  = bus.iData[7];
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: if (div_end) begin
                sck_d   = 1'b1;
                rx_d    = {rx_q[6:0], bus.miso};
                state_d = SHIFT_H;
            end
            SHIFT_H: if (div_end) begin
                sck_d   = 1'b0;
                cnt_d   = cnt_q + 4'd1;
                state_d = SHIFT_L;
                if (cnt_q != 4'd7) begin
                    tx_d   = {tx_q[6:0], 1'b0};
                    mosi_d = tx_q[6];
                end
            end
            // the eighth low phase is a full half-period before HOLD starts
            SHIFT_L: if (div_end) begin
                if (cnt_q == 4'd8) state_d = HOLD;
                else begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[6:0], bus.miso};
                    state_d = SHIFT_H;
                end
            end
            HOLD: if (div_end) begin
                done_d = 1'b1;
                data_d = rx_q;
                if (burst) begin
                    tx_d    = bus.iData;
                    mosi_d  = bus.iData[7];
                    cnt_d   = '0;
                    state_d = SETUP;
                end else begin
                    ncs_d   = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: if (div_end) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            ncs_q   <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            ncs_q   <= ncs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end
    assign bus.oData = data_q;
    assign bus.oDone = done_q;
    assign bus.oBusy = busy_q;
    assign bus.ncs   = ncs_q;
    assign bus.sck   = sck_q;
    assign bus.mosi  = mosi_q;
endmodule

// File: tb/tb_spi_master_module.sv
// tb_spi_master_module: directed checks of three spi_master_module instances (CLK_DIV 2, 1, 4).
module tb_spi_master_module;
    logic clk = 1'b0;
    logic rst;
    logic [2:0]      call;
    logic [2:0][7:0] din, sbyte, w_odat;
    logic [2:0]      w_ncs, w_sck, w_mosi, w_done, w_busy;
    int checks = 0;
    int errors = 0;
    int done_k, done2_k, ndone, nfall, fall2_k, ncs_low, hi_cnt, rises, bad_w, bad_m, busy_low_k, gap_hi;
    logic [15:0] mseq;
    logic [7:0]  d1, d2;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : u
            localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 4;
            spi_master_module_if bus ();
            logic [3:0] idx = 4'd0;
            spi_master_module #(.CLK_DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus));
            assign bus.iCall = call[g];
            assign bus.iData = din[g];
            assign w_odat[g] = bus.oData;
            assign w_ncs[g]  = bus.ncs;
            assign w_sck[g]  = bus.sck;
            assign w_mosi[g] = bus.mosi;
            assign w_done[g] = bus.oDone;
            assign w_busy[g] = bus.oBusy;
            // mode-0 slave: present MSB at ncs fall, advance on every sck fall
            always @(negedge bus.sck or posedge bus.ncs) idx <= bus.ncs ? 4'd0 : idx + 4'd1;
            assign bus.miso = bus.ncs ? 1'b0 : sbyte[g][3'd7 - idx[2:0]];
        end
    endgenerate

    function automatic int dv(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Accepts b1 on instance i, then observes k = 1..n cycles after the acceptance edge.
    // mode 0: single call, iData scrambled afterwards; 1: call held to k=n;
    // 2: extra call pulses at k=5 and k=20; 3: two-byte stimulus, second byte b2.
    task automatic run(input int i, input int n, input int mode, input logic [7:0] b1, input logic [7:0] b2);
        logic ps, pn, pm;
        int hr;
        done_k = 0; done2_k = 0; ndone = 0; nfall = 0; fall2_k = 0; ncs_low = 0;
        hi_cnt = 0; rises = 0; bad_w = 0; bad_m = 0; busy_low_k = 0; gap_hi = 0; mseq = '0;
        d1 = 'x; d2 = 'x; ps = 1'b0; pn = 1'b1; pm = 1'b0; hr = 0;
        din[i] = b1;
        call[i] = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= n; k++) begin
            if (mode == 0 && k == 1) call[i] = 1'b0;
            if (mode == 0 && k == 2) din[i] = ~b1;
            if (mode == 1 && k == n) call[i] = 1'b0;
            if (mode == 2) call[i] = (k == 5 || k == 20);
            if (mode == 3 && k == 1) din[i] = b2;
            if (!w_ncs[i]) ncs_low++;
            if (pn && !w_ncs[i]) begin
                nfall++;
                if (nfall == 2) fall2_k = k;
            end
            if (w_ncs[i] && ndone > 0 && nfall == 1) gap_hi++;
            if (w_sck[i]) begin
                hr++;
                hi_cnt++;
            end else if (ps) begin
                if (hr != dv(i)) bad_w++;
                hr = 0;
            end
            if (!ps && w_sck[i]) begin
                rises++;
                mseq = {mseq[14:0], w_mosi[i]};
            end
            if (ps && w_sck[i] && w_mosi[i] !== pm) bad_m++;
            if (w_done[i]) begin
                ndone++;
                if (ndone == 1) begin
                    done_k = k;
                    d1 = w_odat[i];
                end else begin
                    done2_k = k;
                    d2 = w_odat[i];
                end
            end
            if (ndone > 0 && !w_busy[i] && busy_low_k == 0) busy_low_k = k;
`ifdef SPI_MASTER_BURST_EN
            if (mode == 3 && w_done[i]) call[i] = 1'b0;
`else
            if (mode == 3 && nfall == 2) call[i] = 1'b0;
`endif
            ps = w_sck[i];
            pn = w_ncs[i];
            pm = w_mosi[i];
            if (k < n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        call = '0;
        din = '0;
        sbyte = '0;
        idle(3);
        chk("reset_pins_div2", {w_ncs[0], w_sck[0], w_mosi[0], w_done[0], w_busy[0], w_odat[0]}, 32'h1000);
        chk("reset_pins_div1", {w_ncs[1], w_sck[1], w_mosi[1], w_done[1], w_busy[1], w_odat[1]}, 32'h1000);
        rst = 1'b0;
        idle(2);

        sbyte[0] = 8'h3C;
        run(0, 40, 0, 8'hA5, 8'h00);
        chk("t1_done_k", done_k, 37);
        chk("t1_ndone", ndone, 1);
        chk("t1_odata", d1, 8'h3C);
        chk("t1_mosi_bits", mseq[7:0], 8'hA5);
        chk("t1_sck_rises", rises, 8);
        chk("t1_sck_high_cycles", hi_cnt, 16);
        chk("t1_high_width_bad", bad_w, 0);
        chk("t1_mosi_unstable", bad_m, 0);
        chk("t1_ncs_low_cycles", ncs_low, 36);
        chk("t1_busy_low_k", busy_low_k, 39);
        chk("t1_odata_held", w_odat[0], 8'h3C);
        idle(3);

        sbyte[1] = 8'h00;
        run(1, 20, 1, 8'hFF, 8'h00);
        chk("t2_done_k", done_k, 19);
        chk("t2_odata", d1, 8'h00);
        chk("t2_mosi_bits", mseq[7:0], 8'hFF);
        chk("t2_sck_high_cycles", hi_cnt, 8);
        chk("t2_high_width_bad", bad_w, 0);
        chk("t2_ncs_falls", nfall, 1);
        chk("t2_busy_low_k", busy_low_k, 20);
        idle(5);
        chk("t2_stays_idle", {w_ncs[1], w_busy[1]}, 2'b10);

        sbyte[2] = 8'h5A;
        run(2, 80, 2, 8'h81, 8'h00);
        chk("t3_done_k", done_k, 73);
        chk("t3_ndone", ndone, 1);
        chk("t3_ncs_falls", nfall, 1);
        chk("t3_odata", d1, 8'h5A);
        chk("t3_mosi_bits", mseq[7:0], 8'h81);
        chk("t3_busy_low_k", busy_low_k, 77);
        idle(3);

        sbyte[2] = 8'h66;
        run(2, 29, 0, 8'hA5, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t4_async_reset_pins", {w_ncs[2], w_sck[2], w_mosi[2], w_busy[2], w_done[2]}, 5'b10000);
        idle(3);
        chk("t4_reset_hold", {w_ncs[2], w_done[2], w_busy[2], w_odat[2]}, 11'b100_00000000);
        rst = 1'b0;
        idle(2);
        sbyte[2] = 8'h96;
        run(2, 80, 0, 8'hC3, 8'h00);
        chk("t4_done_k", done_k, 73);
        chk("t4_odata", d1, 8'h96);
        chk("t4_mosi_bits", mseq[7:0], 8'hC3);
        chk("t4_sck_rises", rises, 8);
        chk("t4_high_width_bad", bad_w, 0);
        idle(3);

        sbyte[0] = 8'h3C;
        run(0, 90, 3, 8'h12, 8'h34);
        chk("t5_done_k", done_k, 37);
        chk("t5_odata1", d1, 8'h3C);
        chk("t5_odata2", d2, 8'h3C);
        chk("t5_ndone", ndone, 2);
        chk("t5_mosi_bits", mseq, 16'h1234);
        chk("t5_sck_rises", rises, 16);
        chk("t5_mosi_unstable", bad_m, 0);
`ifdef SPI_MASTER_BURST_EN
        chk("t5_burst_done2_k", done2_k, 73);
        chk("t5_burst_ncs_falls", nfall, 1);
        chk("t5_burst_ncs_low", ncs_low, 72);
`else
        chk("t5_second_accept_k", fall2_k, 40);
        chk("t5_done2_latency", done2_k - fall2_k, 36);
        chk("t5_gap_ge2", gap_hi >= 2, 1);
        chk("t5_ncs_falls", nfall, 2);
`endif
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
